// File: rtl/mem_read_arbi_if.sv
// Read-burst handshake bundle shared by the frame-buffer read channels and the
// DDR2 burst engine read port.
interface mem_read_arbi_if #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned LEN_BITS      = 10
);
    logic                     rd_burst_req;
    logic [LEN_BITS-1:0]      rd_burst_len;
    logic [ADDR_BITS-1:0]     rd_burst_addr;
    logic                     rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     rd_burst_finish;

    // master issues bursts and receives data
    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );
endinterface

// File: rtl/mem_read_arbi.sv
// Two-channel round-robin read-burst arbiter in front of the DDR2 burst engine
// read port; routes returned beats to the granted channel and checks beat counts.
module mem_read_arbi #(
    parameter int unsigned MEM_DATA_BITS = 64,
    parameter int unsigned ADDR_BITS     = 24,
    parameter int unsigned LEN_BITS      = 10
) (
    input  logic            mem_clk,
    input  logic            rst,
    mem_read_arbi_if.slave  ch0,
    mem_read_arbi_if.slave  ch1,
    mem_read_arbi_if.master mem,
    output logic            beat_err,
    output logic            grant_ch
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     req_q, req_d;
    logic [LEN_BITS-1:0]      len_q, len_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [LEN_BITS:0]        cnt_q, cnt_d, cnt_inc;
    logic                     err_q, err_d;
    logic                     grant_q, grant_d;
    logic                     pick;
    logic                     busy;
    logic [MEM_DATA_BITS-1:0] data_w;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        len_d   = len_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        grant_d = grant_q;
        // Contention alternates away from the last grant; a lone request always wins.
        pick    = (ch0.rd_burst_req && ch1.rd_burst_req) ? ~grant_q : ch1.rd_burst_req;
        cnt_inc = (mem.rd_burst_data_valid && (cnt_q != '1)) ?
                  cnt_q + (LEN_BITS+1)'(1) : cnt_q;
        case (state_q)
            IDLE: begin
                if (ch0.rd_burst_req || ch1.rd_burst_req) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    grant_d = pick;
                    len_d   = pick ? ch1.rd_burst_len  : ch0.rd_burst_len;
                    addr_d  = pick ? ch1.rd_burst_addr : ch0.rd_burst_addr;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                // A beat coincident with finish is counted before the length check.
                if (mem.rd_burst_finish) begin
                    state_d = RELEASE;
                    req_d   = 1'b0;
                    if (cnt_inc != {1'b0, len_q}) err_d = 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            grant_q <= grant_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign data_w = mem.rd_burst_data;

    assign mem.rd_burst_req  = req_q;
    assign mem.rd_burst_len  = len_q;
    assign mem.rd_burst_addr = addr_q;

    assign ch0.rd_burst_data_valid = busy && !grant_q && mem.rd_burst_data_valid;
    assign ch0.rd_burst_finish     = busy && !grant_q && mem.rd_burst_finish;
    assign ch0.rd_burst_data       = data_w;
    assign ch1.rd_burst_data_valid = busy && grant_q && mem.rd_burst_data_valid;
    assign ch1.rd_burst_finish     = busy && grant_q && mem.rd_burst_finish;
    assign ch1.rd_burst_data       = data_w;

    assign beat_err = err_q;
    assign grant_ch = grant_q;

endmodule

// File: tb/tb_mem_read_arbi.sv
// Directed bench for mem_read_arbi: transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_read_arbi;
    localparam int unsigned DB = 64;
    localparam int unsigned AB = 24;
    localparam int unsigned LB = 10;

    logic mem_clk = 1'b0;
    logic rst     = 1'b1;
    logic beat_err, grant_ch;

    mem_read_arbi_if #(.MEM_DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) ch0_if ();
    mem_read_arbi_if #(.MEM_DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) ch1_if ();
    mem_read_arbi_if #(.MEM_DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) mem_if ();

    mem_read_arbi #(.MEM_DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .mem_clk (mem_clk),
        .rst     (rst),
        .ch0     (ch0_if.slave),
        .ch1     (ch1_if.slave),
        .mem     (mem_if.master),
        .beat_err(beat_err),
        .grant_ch(grant_ch)
    );

    always #5 mem_clk = ~mem_clk;

    int errors = 0;
    int checks = 0;
    int cnt_v0 = 0, cnt_f0 = 0, cnt_v1 = 0, cnt_f1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the engine, whether the hand-back gap is pending, last winner.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_last  = 1;
    int m_beats = 0;
    bit m_err   = 1'b0;
    int m_len   = 0;
    int m_addr  = 0;
    bit m_req   = 1'b0;

    always @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_gap = 1'b0; m_last = 1; m_beats = 0;
            m_err = 1'b0; m_len = 0; m_addr = 0; m_req = 1'b0;
        end else if (m_owner >= 0) begin
            if (mem_if.rd_burst_data_valid && m_beats < (1 << (LB + 1)) - 1) m_beats++;
            if (mem_if.rd_burst_finish) begin
                if (m_beats != m_len) m_err = 1'b1;
                m_owner = -1;
                m_gap   = 1'b1;
                m_req   = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (ch0_if.rd_burst_req || ch1_if.rd_burst_req) begin
            if (ch0_if.rd_burst_req && ch1_if.rd_burst_req) m_owner = 1 - m_last;
            else m_owner = ch0_if.rd_burst_req ? 0 : 1;
            m_last  = m_owner;
            m_len   = (m_owner == 0) ? int'(ch0_if.rd_burst_len)  : int'(ch1_if.rd_burst_len);
            m_addr  = (m_owner == 0) ? int'(ch0_if.rd_burst_addr) : int'(ch1_if.rd_burst_addr);
            m_beats = 0;
            m_req   = 1'b1;
        end
    end

    always @(negedge mem_clk) begin
        chk("rd_burst_req",  64'(mem_if.rd_burst_req),  64'(m_req));
        chk("rd_burst_len",  64'(mem_if.rd_burst_len),  64'(m_len));
        chk("rd_burst_addr", 64'(mem_if.rd_burst_addr), 64'(m_addr));
        chk("grant_ch",      64'(grant_ch),             64'(m_last));
        chk("beat_err",      64'(beat_err),             64'(m_err));
        chk("ch0_valid",  64'(ch0_if.rd_burst_data_valid), 64'(m_owner == 0 && mem_if.rd_burst_data_valid));
        chk("ch1_valid",  64'(ch1_if.rd_burst_data_valid), 64'(m_owner == 1 && mem_if.rd_burst_data_valid));
        chk("ch0_finish", 64'(ch0_if.rd_burst_finish),     64'(m_owner == 0 && mem_if.rd_burst_finish));
        chk("ch1_finish", 64'(ch1_if.rd_burst_finish),     64'(m_owner == 1 && mem_if.rd_burst_finish));
        chk("ch0_data", ch0_if.rd_burst_data, mem_if.rd_burst_data);
        chk("ch1_data", ch1_if.rd_burst_data, mem_if.rd_burst_data);
        if (ch0_if.rd_burst_data_valid) cnt_v0++;
        if (ch1_if.rd_burst_data_valid) cnt_v1++;
        if (ch0_if.rd_burst_finish)     cnt_f0++;
        if (ch1_if.rd_burst_finish)     cnt_f1++;
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic cyc(input int n);
        repeat (n) begin @(posedge mem_clk); #2; end
    endtask

    task automatic set_ch(input int ch, input bit req, input int len, input int addr);
        if (ch == 0) begin
            ch0_if.rd_burst_req = req; ch0_if.rd_burst_len = LB'(len); ch0_if.rd_burst_addr = AB'(addr);
        end else begin
            ch1_if.rd_burst_req = req; ch1_if.rd_burst_len = LB'(len); ch1_if.rd_burst_addr = AB'(addr);
        end
    endtask

    task automatic clr_counts();
        cnt_v0 = 0; cnt_f0 = 0; cnt_v1 = 0; cnt_f1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    endtask

    // Burst engine: wait for a request, return nbeats, then finish (optionally on the last beat).
    task automatic engine(input int nbeats, input bit coincident);
        int t = 0;
        while (!mem_if.rd_burst_req && t < 20) begin cyc(1); t++; end
        chk("engine_req_wait", 64'(mem_if.rd_burst_req), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            mem_if.rd_burst_data_valid = 1'b1;
            mem_if.rd_burst_data       = {$urandom, $urandom};
            mem_if.rd_burst_finish     = coincident && (i == nbeats - 1);
            cyc(1);
        end
        if (!coincident || nbeats == 0) begin
            mem_if.rd_burst_data_valid = 1'b0;
            mem_if.rd_burst_finish     = 1'b1;
            cyc(1);
        end
        mem_if.rd_burst_data_valid = 1'b0;
        mem_if.rd_burst_finish     = 1'b0;
    endtask

    initial begin
        int gap;
        set_ch(0, 0, 0, 0);
        set_ch(1, 0, 0, 0);
        mem_if.rd_burst_data_valid = 1'b0;
        mem_if.rd_burst_data       = '0;
        mem_if.rd_burst_finish     = 1'b0;
        rst = 1'b1;
        @(negedge mem_clk);
        chk("reset_grant_ch", 64'(grant_ch), 64'd1);
        chk("reset_req",      64'(mem_if.rd_burst_req), 64'd0);
        chk("reset_beat_err", 64'(beat_err), 64'd0);
        @(posedge mem_clk); #2;
        rst = 1'b0; cyc(1);

        // Single ch0 burst, len 16
        clr_counts();
        set_ch(0, 1, 16, 'h000100);
        @(negedge mem_clk);
        chk("t1_req_before_edge", 64'(mem_if.rd_burst_req), 64'd0);
        @(negedge mem_clk);
        chk("t1_req_latency",  64'(mem_if.rd_burst_req),  64'd1);
        chk("t1_addr",         64'(mem_if.rd_burst_addr), 64'h000100);
        chk("t1_len",          64'(mem_if.rd_burst_len),  64'd16);
        @(posedge mem_clk); #2;
        engine(16, 0);
        set_ch(0, 0, 16, 'h000100);
        cyc(2);
        chk("t1_ch0_valids", 64'(cnt_v0), 64'd16);
        chk("t1_ch0_finish", 64'(cnt_f0), 64'd1);
        chk("t1_ch1_valids", 64'(cnt_v1), 64'd0);
        chk("t1_ch1_finish", 64'(cnt_f1), 64'd0);
        chk("t1_beat_err",   64'(beat_err), 64'd0);

        // Contention from reset, ch0 first, then ch1, then ch0 again
        do_reset();
        clr_counts();
        set_ch(0, 1, 4, 'h000A00);
        set_ch(1, 1, 3, 'h00B000);
        cyc(1);
        chk("t2_first_grant", 64'(grant_ch), 64'd0);
        engine(4, 0);
        set_ch(0, 0, 4, 'h000A00);
        cyc(2);
        chk("t2_second_grant", 64'(grant_ch), 64'd1);
        chk("t2_second_addr",  64'(mem_if.rd_burst_addr), 64'h00B000);
        chk("t2_second_len",   64'(mem_if.rd_burst_len),  64'd3);
        engine(3, 0);
        set_ch(1, 0, 3, 'h00B000);
        cyc(3);
        chk("t2_ch1_valids", 64'(cnt_v1), 64'd3);
        set_ch(0, 1, 2, 'h000C00);
        set_ch(1, 1, 2, 'h00D000);
        cyc(1);
        chk("t2_third_grant", 64'(grant_ch), 64'd0);
        engine(2, 0);
        set_ch(0, 0, 0, 0);
        set_ch(1, 0, 0, 0);
        cyc(2);

        // ch1 back-to-back
        clr_counts();
        set_ch(1, 1, 2, 'h00E000);
        engine(2, 0);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mem_clk);
            if (mem_if.rd_burst_req) break;
            gap++;
        end
        chk("t3_req_gap", 64'(gap), 64'd2);
        @(posedge mem_clk); #2;
        chk("t3_regrant", 64'(grant_ch), 64'd1);
        engine(2, 0);
        set_ch(1, 0, 0, 0);
        cyc(2);
        chk("t3_ch1_finish", 64'(cnt_f1), 64'd2);
        chk("t3_ch0_valids", 64'(cnt_v0), 64'd0);

        // Short burst sets sticky beat_err
        set_ch(0, 1, 8, 'h001000);
        engine(7, 0);
        chk("t4_err_set", 64'(beat_err), 64'd1);
        set_ch(0, 0, 8, 'h001000);
        cyc(1);
        set_ch(0, 1, 4, 'h002000);
        engine(4, 0);
        set_ch(0, 0, 4, 'h002000);
        cyc(2);
        chk("t4_err_sticky", 64'(beat_err), 64'd1);

        // Stray beats in IDLE, coincident finish, zero-length burst
        do_reset();
        mem_if.rd_burst_data_valid = 1'b1;
        cyc(2);
        mem_if.rd_burst_data_valid = 1'b0;
        set_ch(0, 1, 8, 'h003000);
        engine(8, 1);
        set_ch(0, 0, 8, 'h003000);
        cyc(2);
        chk("t5_coincident_err", 64'(beat_err), 64'd0);
        set_ch(1, 1, 0, 'h004000);
        engine(0, 0);
        set_ch(1, 0, 0, 'h004000);
        cyc(2);
        chk("t5_len0_err",   64'(beat_err), 64'd0);
        chk("t5_len0_grant", 64'(grant_ch), 64'd1);

        // Reset mid-burst
        clr_counts();
        set_ch(0, 1, 10, 'h005000);
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            mem_if.rd_burst_data_valid = 1'b1;
            mem_if.rd_burst_data       = {$urandom, $urandom};
            cyc(1);
        end
        mem_if.rd_burst_finish = 1'b1;
        rst = 1'b1;
        @(negedge mem_clk);
        chk("t6_rst_req",    64'(mem_if.rd_burst_req),  64'd0);
        chk("t6_rst_len",    64'(mem_if.rd_burst_len),  64'd0);
        chk("t6_rst_addr",   64'(mem_if.rd_burst_addr), 64'd0);
        chk("t6_rst_grant",  64'(grant_ch), 64'd1);
        chk("t6_rst_valid0", 64'(ch0_if.rd_burst_data_valid), 64'd0);
        chk("t6_rst_fin0",   64'(ch0_if.rd_burst_finish), 64'd0);
        @(posedge mem_clk); #2;
        set_ch(0, 0, 0, 0);
        mem_if.rd_burst_data_valid = 1'b0;
        mem_if.rd_burst_finish     = 1'b0;
        rst = 1'b0;
        cyc(1);
        chk("t6_ch0_finish_none", 64'(cnt_f0), 64'd0);
        set_ch(0, 1, 3, 'h006000);
        cyc(1);
        chk("t6_fresh_grant", 64'(grant_ch), 64'd0);
        chk("t6_fresh_addr",  64'(mem_if.rd_burst_addr), 64'h006000);
        engine(3, 0);
        set_ch(0, 0, 0, 0);
        cyc(2);
        chk("t6_fresh_finish", 64'(cnt_f0), 64'd1);
        chk("t6_fresh_err",    64'(beat_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_read_arbi.md
Name: mem_read_arbi

Overview:
- Two-channel round-robin read-burst arbiter.
- Sits between two video-out frame buffer read controllers and the single read port of the DDR2 burst engine (mem_burst_v2), in the mem_clk domain.
- Grants one channel at a time, forwards its burst request, and routes read data, valid and finish back to the granted channel only.
- Counts returned beats and flags length mismatches.

Parameters:
- MEM_DATA_BITS, 64, read data width.
- ADDR_BITS, 24, burst address width.
- LEN_BITS, 10, burst length width in beats.

Ports:
- mem_clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ch0_rd_burst_req  in  1  channel 0 request; level, held until its finish.
- ch0_rd_burst_len  in  LEN_BITS  channel 0 burst length in beats.
- ch0_rd_burst_addr  in  ADDR_BITS  channel 0 start address.
- ch0_rd_burst_data_valid  out  1  valid beat for channel 0.
- ch0_rd_burst_data  out  MEM_DATA_BITS  read data (broadcast).
- ch0_rd_burst_finish  out  1  one-cycle finish pulse to channel 0.
- ch1_rd_burst_req / _len / _addr / _data_valid / _data / _finish  same widths and meaning, channel 1.
- rd_burst_req  out  1  request to burst engine.
- rd_burst_len  out  LEN_BITS  granted length.
- rd_burst_addr  out  ADDR_BITS  granted address.
- rd_burst_data_valid  in  1  beat valid from burst engine.
- rd_burst_data  in  MEM_DATA_BITS  beat data.
- rd_burst_finish  in  1  burst complete pulse.
- beat_err  out  1  sticky: a finish arrived with beat count different from granted length.
- grant_ch  out  1  index of the current or last granted channel.

Behaviour:
- Reset values (async on rst high): state IDLE, rd_burst_req 0, rd_burst_len 0, rd_burst_addr 0, beat counter 0, beat_err 0, grant_ch 1 (so channel 0 wins first), all chN finish/valid 0.
- FSM states:
  - IDLE -> BUSY when any chN_rd_burst_req is high. Register grant, len and addr; rd_burst_req asserts on the next edge (1-cycle latency from request).
  - BUSY: rd_burst_req, rd_burst_len and rd_burst_addr held stable. When rd_burst_finish is high -> RELEASE, and rd_burst_req drops on that same edge.
  - RELEASE: one cycle, no grant. Lets the served channel drop its level request. -> IDLE.
- Round robin:
  - Both requests high in IDLE -> grant the channel other than grant_ch.
  - Single request -> grant it regardless of grant_ch.
- Routing (combinational from inputs, gated by state==BUSY and grant_ch):
  - chN_rd_burst_data_valid = rd_burst_data_valid for the granted channel; 0 otherwise.
  - chN_rd_burst_finish = rd_burst_finish for the granted channel; 0 otherwise.
  - chN_rd_burst_data = rd_burst_data for both channels, unconditionally.
- Zero added latency on the data path.
- Beats arriving outside BUSY are dropped and not counted.
- Beat counter (LEN_BITS+1 wide, saturating):
  - Cleared on grant.
  - Increments per valid beat in BUSY.
  - On finish, if count != registered len, beat_err sets and stays set until rst.
- A request that drops while granted (before finish) does not abort: BUSY holds until rd_burst_finish.
- A finish arriving in the same cycle as the last valid beat counts that beat before the compare.
- rd_burst_len of 0 is forwarded unchanged; a finish with 0 beats then passes the length check.
- rst asserted mid-burst: immediate return to reset values. No finish pulse is generated to any channel.

Test Plan:
- Ch0 request, len=16, addr=0x000100; engine returns 16 beats then finish -> rd_burst_req high 1 cycle after request; ch0 sees 16 valids and 1 finish; ch1 sees none; beat_err 0.
- Both requests high from reset -> ch0 granted first. After its finish plus the RELEASE cycle, ch1 granted with its own len/addr. Next contention -> ch0 again.
- Ch1 requesting continuously, ch0 idle -> ch1 re-granted back-to-back with exactly one RELEASE cycle between bursts.
- Grant len=8 but engine returns 7 beats then finish -> beat_err rises on the finish cycle and stays high across later correct bursts.
- Finish coincident with 8th valid beat, len=8 -> beat_err stays 0.
- rst pulsed after 5 beats of a ch0 burst -> all outputs 0 and grant_ch=1 while rst is high; afterwards a fresh ch0 request is granted normally.
